ex_stage: RTL

- Execute stage; consumes the operand/op bundle registered by the ID/EX pipeline register and feeds the EX/MEM register.
- Single-cycle ALU paths: logic, shift, arith, move, jump-link.
- Multi-cycle paths: a 2-cycle multiply-accumulate (MADD/MSUB family) and a 32-iteration radix-2 divider (DIV/DIVU).
- Raises stallreq_o toward the stall controller while a multi-cycle op is in flight.

---
 rtl/ex_stage_pkg.sv | 57 +++++
 rtl/ex_stage_div_iter.sv | 93 +++++++++
 rtl/ex_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op/sel encodings, bus
// widths, the exception bit used for arithmetic overflow, divider states
// and a small magnitude helper used by the divider.
package ex_stage_pkg;

  localparam int ALU_OP_W     = 8;
  localparam int ALU_SEL_W    = 3;
  localparam int EXC_W        = 32;
  localparam int OVERFLOW_BIT = 11;

  // Result classes (alusel)
  localparam logic [ALU_SEL_W-1:0] SEL_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] SEL_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] SEL_MOVE  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] SEL_ARITH = 3'b100;
  localparam logic [ALU_SEL_W-1:0] SEL_JB    = 3'b110;

  // Operation codes (aluop)
  localparam logic [ALU_OP_W-1:0] OP_NOP   = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] OP_AND   = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] OP_OR    = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] OP_XOR   = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] OP_NOR   = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] OP_SLL   = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] OP_SRL   = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] OP_SRA   = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] OP_SLT   = 8'b0010_1010;
  localparam logic [ALU_OP_W-1:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [ALU_OP_W-1:0] OP_ADD   = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [ALU_OP_W-1:0] OP_SUB   = 8'b0010_0010;
  localparam logic [ALU_OP_W-1:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [ALU_OP_W-1:0] OP_ADDI  = 8'b0101_0101;
  localparam logic [ALU_OP_W-1:0] OP_ADDIU = 8'b0101_0110;
  localparam logic [ALU_OP_W-1:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [ALU_OP_W-1:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [ALU_OP_W-1:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [ALU_OP_W-1:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [ALU_OP_W-1:0] OP_MULT  = 8'b0001_1000;
  localparam logic [ALU_OP_W-1:0] OP_MULTU = 8'b0001_1001;
  localparam logic [ALU_OP_W-1:0] OP_DIV   = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [ALU_OP_W-1:0] OP_MADD  = 8'b1010_0110;
  localparam logic [ALU_OP_W-1:0] OP_MADDU = 8'b1010_1000;
  localparam logic [ALU_OP_W-1:0] OP_MSUB  = 8'b1010_1010;
  localparam logic [ALU_OP_W-1:0] OP_MSUBU = 8'b1010_1011;

  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_e;

  // Magnitude of v when interpreted as signed (sgn=1), else v unchanged.
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk/rst (async high), signed_i selects DIV vs DIVU, op1_i dividend,
// op2_i divisor, start_i request, annul_i abort; result_o = {rem, quo},
// ready_o high for the whole END state.
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int ITER_W = $clog2(DIV_ITER);

  div_state_e        state;
  logic [ITER_W-1:0] iter;
  logic [31:0]       quo, rem, dvsr;
  logic              neg_q, neg_r;

  // One subtract-shift step: bring the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  logic [32:0] part;
  logic        fits;
  logic [31:0] rem_n, quo_n;

  assign part  = {rem, quo[31]};
  assign fits  = part >= {1'b0, dvsr};
  assign rem_n = fits ? (part[31:0] - dvsr) : part[31:0];
  assign quo_n = {quo[30:0], fits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_FREE;
      iter     <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      state   <= DIV_FREE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: if (start_i) begin
          if (op2_i == '0) begin
            state <= DIV_BYZERO;
          end else begin
            state <= DIV_ON;
            iter  <= '0;
            quo   <= mag32(signed_i, op1_i);
            rem   <= '0;
            dvsr  <= mag32(signed_i, op2_i);
            // Quotient negative on sign mismatch, remainder follows dividend.
            neg_q <= signed_i & (op1_i[31] ^ op2_i[31]);
            neg_r <= signed_i & op1_i[31];
          end
        end
        DIV_BYZERO: begin
          state    <= DIV_END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        DIV_ON: begin
          quo  <= quo_n;
          rem  <= rem_n;
          iter <= iter + 1'b1;
          if (iter == ITER_W'(DIV_ITER - 1)) begin
            state    <= DIV_END;
            ready_o  <= 1'b1;
            result_o <= {neg_r ? -rem_n : rem_n, neg_q ? -quo_n : quo_n};
          end
        end
        DIV_END: if (!start_i) begin
          state   <= DIV_FREE;
          ready_o <= 1'b0;
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage. Single-cycle logic/shift/arith/move/link results, single
// cycle MULT/MULTU, 2-cycle MADD/MSUB family and a multi-cycle divider.
// Inputs: ID/EX bundle (aluop/alusel/operands/dest/except/PC), forwarded
// hi_i/lo_i, flush. Outputs: EX/MEM bundle (wd/wreg/wdata, HI/LO write,
// merged exception flags, passthroughs) and stallreq_o toward stall control.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [ALU_OP_W-1:0]  aluop_i,
  input  logic [ALU_SEL_W-1:0] alusel_i,
  input  logic [31:0]          reg1_i,
  input  logic [31:0]          reg2_i,
  input  logic [4:0]           wd_i,
  input  logic                 wreg_i,
  input  logic [31:0]          inst_i,
  input  logic [31:0]          link_address_i,
  input  logic                 is_in_delayslot_i,
  input  logic [EXC_W-1:0]     excepttype_i,
  input  logic [31:0]          current_inst_address_i,
  input  logic [31:0]          hi_i,
  input  logic [31:0]          lo_i,
  output logic [4:0]           wd_o,
  output logic                 wreg_o,
  output logic [31:0]          wdata_o,
  output logic                 whilo_o,
  output logic [31:0]          hi_o,
  output logic [31:0]          lo_o,
  output logic                 stallreq_o,
  output logic [EXC_W-1:0]     excepttype_o,
  output logic [31:0]          current_inst_address_o,
  output logic                 is_in_delayslot_o
);

  // The instruction word is not needed by any EX path.
  logic unused_inst;
  assign unused_inst = ^inst_i;

  assign wd_o                   = wd_i;
  assign is_in_delayslot_o      = is_in_delayslot_i;
  assign current_inst_address_o = current_inst_address_i;

  // ---------------- single-cycle datapaths ----------------
  logic [31:0] sum, diff, logic_res, shift_res, arith_res, move_res;
  logic        ov;

  assign sum  = reg1_i + reg2_i;
  assign diff = reg1_i - reg2_i;
  // Signed overflow: add when like-signed operands yield a different sign,
  // subtract when unlike-signed operands yield a sign different from reg1.
  assign ov = (((aluop_i == OP_ADD) || (aluop_i == OP_ADDI)) &&
               (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31])) ||
              ((aluop_i == OP_SUB) &&
               (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]));

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    move_res  = '0;
    case (aluop_i)
      OP_AND: logic_res = reg1_i & reg2_i;
      OP_OR:  logic_res = reg1_i | reg2_i;
      OP_XOR: logic_res = reg1_i ^ reg2_i;
      OP_NOR: logic_res = ~(reg1_i | reg2_i);
      default: ;
    endcase
    case (aluop_i)
      OP_SLL: shift_res = reg2_i << reg1_i[4:0];
      OP_SRL: shift_res = reg2_i >> reg1_i[4:0];
      OP_SRA: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default: ;
    endcase
    case (aluop_i)
      OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: arith_res = sum;
      OP_SUB, OP_SUBU: arith_res = diff;
      OP_SLT:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: arith_res = {31'b0, reg1_i < reg2_i};
      default: ;
    endcase
    case (aluop_i)
      OP_MFHI: move_res = hi_i;
      OP_MFLO: move_res = lo_i;
      default: ;
    endcase
  end

  always_comb begin
    wdata_o = '0;
    if (!rst) begin
      case (alusel_i)
        SEL_LOGIC: wdata_o = logic_res;
        SEL_SHIFT: wdata_o = shift_res;
        SEL_ARITH: wdata_o = arith_res;
        SEL_MOVE:  wdata_o = move_res;
        SEL_JB:    wdata_o = link_address_i;
        default:   wdata_o = '0;
      endcase
    end
  end

  assign wreg_o = ~rst & wreg_i & ~ov;

  always_comb begin
    excepttype_o               = excepttype_i;
    excepttype_o[OVERFLOW_BIT] = excepttype_i[OVERFLOW_BIT] | ov;
  end

  // ---------------- multiply / multiply-accumulate ----------------
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u, madd_prod, madd_term;
  logic               is_madd, madd_sub, madd_signed;
  logic               cnt;
  logic [63:0]        hilo_temp;

  assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
  assign prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};

  assign madd_sub    = (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
  assign madd_signed = (aluop_i == OP_MADD) || (aluop_i == OP_MSUB);
  assign is_madd     = madd_sub || madd_signed ||
                       (aluop_i == OP_MADDU);
  assign madd_prod   = madd_signed ? prod_s : prod_u;
  assign madd_term   = madd_sub ? -madd_prod : madd_prod;

  // cnt=0: capture (possibly negated) product; cnt=1: accumulate into HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 1'b0;
      hilo_temp <= '0;
    end else if (flush) begin
      cnt <= 1'b0;
    end else if (is_madd && !cnt) begin
      hilo_temp <= madd_term;
      cnt       <= 1'b1;
    end else begin
      cnt <= 1'b0;
    end
  end

  // ---------------- divider ----------------
  logic        is_div, div_start, div_ready;
  logic [63:0] div_result;

  assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  // Dropping start in END lets the divider fall back to FREE.
  assign div_start = is_div & ~div_ready;

  div_iter #(.DIV_ITER(DIV_ITER)) u_div (
    .clk      (clk),
    .rst      (rst),
    .signed_i (aluop_i == OP_DIV),
    .op1_i    (reg1_i),
    .op2_i    (reg2_i),
    .start_i  (div_start),
    .annul_i  (flush),
    .result_o (div_result),
    .ready_o  (div_ready)
  );

  // ---------------- HI/LO write and stall ----------------
  always_comb begin
    whilo_o = 1'b0;
    hi_o    = '0;
    lo_o    = '0;
    if (!rst) begin
      case (aluop_i)
        OP_MTHI: begin whilo_o = 1'b1; hi_o = reg1_i; lo_o = lo_i;   end
        OP_MTLO: begin whilo_o = 1'b1; hi_o = hi_i;   lo_o = reg1_i; end
        OP_MULT:  begin whilo_o = 1'b1; {hi_o, lo_o} = prod_s; end
        OP_MULTU: begin whilo_o = 1'b1; {hi_o, lo_o} = prod_u; end
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:
          if (cnt && !flush) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = hilo_temp + {hi_i, lo_i};
          end
        OP_DIV, OP_DIVU:
          if (div_ready && !flush) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = div_result;
          end
        default: ;
      endcase
    end
  end

  assign stallreq_o = ~rst & ((is_madd & ~cnt) | (is_div & ~div_ready));

endmodule
